ascon_stream_ctrl: RTL and testbench

Byte-stream front end that drives one AsconCore instance as its initiator.
- Load side: assembles key, nonce, associated data and input data from an 8-bit valid/ready input stream into holding registers.
- Core side: issues the core start/acknowledge handshake, then captures the core's output data and tag.
- Output side: serializes output data and tag onto an 8-bit valid/ready output stream.
- Sits between the host byte interface and the AEAD core; owns all core input registers.

---
 rtl/ascon_stream_pkg.sv | 21 ++
 rtl/ascon_byte_serializer.sv | 45 ++++
 rtl/ascon_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ascon_stream_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_stream_pkg.sv
// ascon_stream_pkg: shared states, field sizes and status codes for the Ascon byte-stream front end.
// KEY/AD/DATA_BYTES are the default core geometry; the top derives its own from K, L and Y.
package ascon_stream_pkg;
    typedef enum logic [3:0] {
        LD_KEY, LD_NONCE, LD_AD, LD_DATA, LD_TAG, START, WAIT, ACK, SEND_DATA, SEND_TAG
    } state_t;
    localparam int KEY_BYTES   = 16;
    localparam int NONCE_BYTES = 16;
    localparam int AD_BYTES    = 5;
    localparam int DATA_BYTES  = 13;
    localparam int TAG_BYTES   = 16;
    localparam logic [7:0] STAT_OK   = 8'h01;
    localparam logic [7:0] STAT_FAIL = 8'h00;
    function automatic int cnt_width(input int kb, input int ab, input int db);
        int m;
        m = (kb > NONCE_BYTES) ? kb : NONCE_BYTES;
        m = (ab > m) ? ab : m;
        m = (db > m) ? db : m;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/ascon_byte_serializer.sv
// ascon_byte_serializer: parallel-load register shifted out MSB byte first on a valid/ready stream.
// A nonzero remaining-byte count is the valid flag; o_done marks acceptance of the final byte.
module ascon_byte_serializer #(
    parameter int W  = 128,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [W-1:0]  i_din,
    input  logic [CW-1:0] i_count,
    input  logic          i_last_en,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [7:0]    o_data,
    output logic          o_last,
    output logic          o_done
);
    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_cnt;
    logic          r_last_en;
    logic          w_fire;

    assign o_valid = r_cnt != '0;
    assign w_fire  = o_valid && i_ready;
    assign o_data  = r_sh[W-1 -: 8];
    assign o_last  = r_last_en && (r_cnt == CW'(1));
    assign o_done  = w_fire && (r_cnt == CW'(1));

    // a load wins over a shift so the next phase starts on the cycle the previous one ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh      <= '0;
            r_cnt     <= '0;
            r_last_en <= 1'b0;
        end else if (i_load) begin
            r_sh      <= i_din;
            r_cnt     <= i_count;
            r_last_en <= i_last_en;
        end else if (w_fire) begin
            r_sh  <= r_sh << 8;
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/ascon_stream_ctrl.sv
// ascon_stream_ctrl: byte-stream front end owning the AsconCore inputs, handshake and output serialization.
// ASCON_TAG_CHECK_EN adds an expected-tag load and a pass/fail status byte in decrypt mode.
module ascon_stream_ctrl
    import ascon_stream_pkg::*;
#(
    parameter int K = KEY_BYTES * 8,
    parameter int L = AD_BYTES * 8,
    parameter int Y = DATA_BYTES * 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [7:0]                 s_data,
    input  logic                       s_decrypt,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7:0]                 m_data,
    output logic                       m_last,
    output logic                       busy,
    output logic [K-1:0]               core_key,
    output logic [127:0]               core_nonce,
    output logic [((L > 0) ? L : 1)-1:0] core_ad,
    output logic [((Y > 0) ? Y : 1)-1:0] core_data,
    output logic                       core_decrypt,
    output logic                       core_start,
    input  logic [((Y > 0) ? Y : 1)-1:0] core_out,
    input  logic [127:0]               core_tag,
    input  logic                       core_ready
);
    localparam int KB = K / 8;
    localparam int AB = L / 8;
    localparam int DB = Y / 8;
    localparam int AW = (L > 0) ? L : 1;
    localparam int YW = (Y > 0) ? Y : 1;
    localparam int SW = (Y > 128) ? Y : 128;
    localparam int CW = cnt_width(KB, AB, DB);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [K-1:0]  r_key;
    logic [127:0]  r_nonce;
    logic [AW-1:0] r_ad;
    logic [YW-1:0] r_data;
    logic          r_dec;
    logic [YW-1:0] r_out;
    logic [127:0]  r_tag;
    logic          w_load_st, w_acc, w_field_end, w_chk, w_match, w_pass;
    logic [CW-1:0] w_nbytes;
    logic          w_ser_load, w_ser_done, w_to_tag;
    logic [SW-1:0] w_ser_din;
    logic [CW-1:0] w_ser_cnt;

`ifdef ASCON_TAG_CHECK_EN
    logic [127:0] r_exp;
    always_ff @(posedge clk) begin
        if (rst)
            r_exp <= '0;
        else if (w_acc && r_state == LD_TAG)
            r_exp <= {r_exp[119:0], s_data};
    end
    assign w_chk   = r_dec;
    assign w_match = r_tag == r_exp;
`else
    assign w_chk   = 1'b0;
    assign w_match = 1'b1;
`endif

    assign w_pass      = !w_chk || w_match;
    assign w_load_st   = r_state inside {LD_KEY, LD_NONCE, LD_AD, LD_DATA, LD_TAG};
    assign s_ready     = !rst && w_load_st;
    assign w_acc       = s_valid && s_ready;
    assign w_nbytes    = (r_state == LD_KEY)   ? CW'(KB) :
                         (r_state == LD_NONCE) ? CW'(NONCE_BYTES) :
                         (r_state == LD_AD)    ? CW'(AB) :
                         (r_state == LD_DATA)  ? CW'(DB) : CW'(TAG_BYTES);
    assign w_field_end = w_acc && (r_cnt == w_nbytes - 1'b1);

    assign busy         = (r_state != LD_KEY) || (r_cnt != '0);
    assign core_start   = (r_state == START) || (r_state == ACK);
    assign core_key     = r_key;
    assign core_nonce   = r_nonce;
    assign core_ad      = r_ad;
    assign core_data    = r_data;
    assign core_decrypt = r_dec;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= LD_KEY;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LD_KEY:    if (w_field_end) w_next = LD_NONCE;
            LD_NONCE:  if (w_field_end) w_next = (AB > 0) ? LD_AD : (DB > 0) ? LD_DATA : w_chk ? LD_TAG : START;
            LD_AD:     if (w_field_end) w_next = (DB > 0) ? LD_DATA : w_chk ? LD_TAG : START;
            LD_DATA:   if (w_field_end) w_next = w_chk ? LD_TAG : START;
            LD_TAG:    if (w_field_end) w_next = START;
            START:     w_next = WAIT;
            WAIT:      if (core_ready) w_next = ACK;
            ACK:       w_next = (DB > 0) ? SEND_DATA : SEND_TAG;
            SEND_DATA: if (w_ser_done) w_next = SEND_TAG;
            SEND_TAG:  if (w_ser_done) w_next = LD_KEY;
            default:   w_next = LD_KEY;
        endcase
    end

    // fields fill LSB-first so the first byte of each field ends up in its MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_key   <= '0;
            r_nonce <= '0;
            r_ad    <= '0;
            r_data  <= '0;
            r_dec   <= 1'b0;
            r_out   <= '0;
            r_tag   <= '0;
        end else begin
            if (w_acc) begin
                r_cnt <= w_field_end ? '0 : r_cnt + 1'b1;
                if (r_state == LD_KEY)
                    r_key <= K'({r_key, s_data});
                if (r_state == LD_KEY && r_cnt == '0)
                    r_dec <= s_decrypt;
                if (r_state == LD_NONCE)
                    r_nonce <= {r_nonce[119:0], s_data};
                if (r_state == LD_AD)
                    r_ad <= AW'({r_ad, s_data});
                if (r_state == LD_DATA)
                    r_data <= YW'({r_data, s_data});
            end
            if (r_state == WAIT && core_ready) begin
                r_out <= core_out;
                r_tag <= core_tag;
            end
        end
    end

    // data goes out first when present; the tag phase carries either the tag or the check status
    assign w_ser_load = (r_state == ACK) || (r_state == SEND_DATA && w_ser_done);
    assign w_to_tag   = !(r_state == ACK && DB > 0);
    assign w_ser_din  = !w_to_tag ? SW'(w_pass ? r_out : '0) << (SW - YW) :
                        w_chk     ? SW'(w_match ? STAT_OK : STAT_FAIL) << (SW - 8) :
                                    SW'(r_tag) << (SW - 128);
    assign w_ser_cnt  = !w_to_tag ? CW'(DB) : w_chk ? CW'(1) : CW'(TAG_BYTES);

    ascon_byte_serializer #(.W(SW), .CW(CW)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_ser_load),
        .i_din     (w_ser_din),
        .i_count   (w_ser_cnt),
        .i_last_en (w_to_tag),
        .i_ready   (m_ready),
        .o_valid   (m_valid),
        .o_data    (m_data),
        .o_last    (m_last),
        .o_done    (w_ser_done)
    );
endmodule

// File: tb/tb_ascon_stream_ctrl.sv
// tb_ascon_stream_ctrl: directed and random transactions against a stand-in core and a byte-level reference.
// Honours ASCON_TAG_CHECK_EN for the decrypt tag-check expectations.
module tb_ascon_stream_ctrl;
    localparam int LAT = 6;
    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0, rst = 1'b1;
    logic         s_valid = 1'b0, s_decrypt = 1'b0, m_ready = 1'b1;
    logic [7:0]   s_data = 8'h00;
    logic         s_ready, m_valid, m_last, busy, core_decrypt, core_start;
    logic [7:0]   m_data;
    logic [127:0] core_key, core_nonce;
    logic [39:0]  core_ad;
    logic [103:0] core_data;
    logic [103:0] core_out = '0;
    logic [127:0] core_tag = '0;
    logic         core_ready = 1'b0;
    int           total = 0, bad = 0;

    always #5 clk = ~clk;

    ascon_stream_ctrl #(.K(128), .L(40), .Y(104)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_decrypt(s_decrypt), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .core_key(core_key), .core_nonce(core_nonce),
        .core_ad(core_ad), .core_data(core_data), .core_decrypt(core_decrypt),
        .core_start(core_start), .core_out(core_out), .core_tag(core_tag), .core_ready(core_ready)
    );

    // stand-in cipher: XOR keystream plus a tag over the plaintext, so decryption inverts encryption
    function automatic logic [103:0] ks_fn(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a);
        return k[103:0] ^ n[127:24] ^ {a, a, a[39:16]};
    endfunction
    function automatic logic [127:0] tag_fn(input logic [127:0] k, input logic [127:0] n,
                                            input logic [39:0] a, input logic [103:0] pt);
        return {k[63:0], k[127:64]} ^ n ^ {pt, 24'h5A5A5A} ^ {88'h0, a};
    endfunction

    logic         c_busy = 1'b0, c_dec = 1'b0;
    int           c_timer = 0, c_starts = 0, c_stab_err = 0;
    logic [127:0] c_key = '0, c_nonce = '0;
    logic [39:0]  c_ad = '0;
    logic [103:0] c_data = '0;

    always @(posedge clk) begin
        if (core_start) c_starts <= c_starts + 1;
        if (!rst && (c_busy || core_ready) &&
            (core_key !== c_key || core_nonce !== c_nonce || core_ad !== c_ad ||
             core_data !== c_data || core_decrypt !== c_dec))
            c_stab_err <= c_stab_err + 1;
        if (rst) begin
            c_busy     <= 1'b0;
            core_ready <= 1'b0;
        end else if (!c_busy && !core_ready) begin
            if (core_start) begin
                c_busy  <= 1'b1;
                c_timer <= LAT;
                c_key   <= core_key;
                c_nonce <= core_nonce;
                c_ad    <= core_ad;
                c_data  <= core_data;
                c_dec   <= core_decrypt;
            end
        end else if (c_busy) begin
            if (c_timer == 0) begin
                c_busy     <= 1'b0;
                core_ready <= 1'b1;
                core_out   <= c_data ^ ks_fn(c_key, c_nonce, c_ad);
                core_tag   <= tag_fn(c_key, c_nonce, c_ad,
                                     c_dec ? (c_data ^ ks_fn(c_key, c_nonce, c_ad)) : c_data);
            end else
                c_timer <= c_timer - 1;
        end else if (core_start)
            core_ready <= 1'b0;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                         input logic [103:0] d, input logic dec, input logic [127:0] et, output bq_t q);
        logic [103:0] o;
        logic [127:0] t;
        logic         tag_mode;
        o = d ^ ks_fn(k, n, a);
        t = tag_fn(k, n, a, dec ? o : d);
        tag_mode = 1'b0;
        q = {};
`ifdef ASCON_TAG_CHECK_EN
        tag_mode = dec;
`endif
        for (int i = 12; i >= 0; i--) q.push_back((tag_mode && t != et) ? 8'h00 : o[i*8 +: 8]);
        if (tag_mode)
            q.push_back(t == et ? 8'h01 : 8'h00);
        else
            for (int i = 15; i >= 0; i--) q.push_back(t[i*8 +: 8]);
    endtask

    task automatic feed(input string nm, input bq_t q, input logic dec, input logic gappy);
        int i, cyc;
        logic v;
        i = 0;
        cyc = 0;
        while (i < q.size() && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            v = gappy ? ($urandom_range(0, 2) == 0) : 1'b1;
            s_valid = v;
            s_data = q[i];
            s_decrypt = (i == 0) ? dec : 1'($urandom);
            if (v && s_ready) i++;
        end
        chk({nm, "_fed"}, i, q.size());
        @(negedge clk);
        s_valid = 1'b0;
        s_decrypt = 1'($urandom);
    endtask

    task automatic collect(input string nm, input bq_t exp, input int stall_idx, input int stall_len,
                           input logic rnd_ready, output bq_t got);
        int idx, cyc, left;
        logic first;
        idx = 0;
        cyc = 0;
        left = stall_len;
        first = 1'b1;
        got = {};
        while (idx < exp.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                chk({nm, "_wait_sready"}, s_ready, 0);
                chk({nm, "_wait_busy"}, busy, 1);
                first = 1'b0;
            end
            if (m_valid && idx == stall_idx && left > 0) begin
                m_ready = 1'b0;
                left--;
                chk({nm, "_stall_data"}, m_data, exp[idx]);
                chk({nm, "_stall_last"}, m_last, idx == exp.size() - 1);
            end else begin
                m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_valid && m_ready) begin
                    chk($sformatf("%s_byte%0d", nm, idx), m_data, exp[idx]);
                    chk($sformatf("%s_last%0d", nm, idx), m_last, idx == exp.size() - 1);
                    got.push_back(m_data);
                    idx++;
                end
            end
        end
        chk({nm, "_count"}, idx, exp.size());
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk({nm, "_no_extra"}, m_valid, 0);
        chk({nm, "_idle_busy"}, busy, 0);
    endtask

    task automatic build(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                         input logic [103:0] d, input logic dec, input logic [127:0] et, output bq_t q);
        q = {};
        for (int i = 15; i >= 0; i--) q.push_back(k[i*8 +: 8]);
        for (int i = 15; i >= 0; i--) q.push_back(n[i*8 +: 8]);
        for (int i = 4; i >= 0; i--) q.push_back(a[i*8 +: 8]);
        for (int i = 12; i >= 0; i--) q.push_back(d[i*8 +: 8]);
`ifdef ASCON_TAG_CHECK_EN
        if (dec) for (int i = 15; i >= 0; i--) q.push_back(et[i*8 +: 8]);
`else
        if (dec && et === 'x) q.push_back(8'h00);
`endif
    endtask

    task automatic run_txn(input string nm, input logic [127:0] k, input logic [127:0] n,
                           input logic [39:0] a, input logic [103:0] d, input logic dec,
                           input logic [127:0] et, input logic gappy, input int stall_idx,
                           input int stall_len, input logic rnd_ready, output bq_t got);
        bq_t q, exp;
        int s0;
        build(k, n, a, d, dec, et, q);
        model(k, n, a, d, dec, et, exp);
        s0 = c_starts;
        feed(nm, q, dec, gappy);
        collect(nm, exp, stall_idx, stall_len, rnd_ready, got);
        chk({nm, "_starts"}, c_starts - s0, 2);
        chk({nm, "_core_key"}, c_key, k);
        chk({nm, "_core_nonce"}, c_nonce, n);
        chk({nm, "_core_ad"}, c_ad, a);
        chk({nm, "_core_data"}, c_data, d);
        chk({nm, "_core_dec"}, c_dec, dec);
        chk({nm, "_stable"}, c_stab_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key, nonce, et;
        logic [39:0]  ad;
        logic [103:0] data, ct;
        bq_t          ref_out, got;
        key   = 128'h000102030405060708090A0B0C0D0E0F;
        nonce = 128'h000102030405060708090A0B0C0D0E0F;
        ad    = 40'h0001020304;
        data  = 104'h000102030405060708090A0B0C;

        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_decrypt", core_decrypt, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_s_ready", s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", s_ready, 1);

        run_txn("enc", key, nonce, ad, data, 1'b0, '0, 1'b0, -1, 0, 1'b0, ref_out);
        chk("enc_size", ref_out.size(), 29);

        ct = '0;
        et = '0;
        for (int i = 0; i < 13; i++) ct = {ct[95:0], ref_out[i]};
        for (int i = 13; i < 29; i++) et = {et[119:0], ref_out[i]};
        run_txn("dec", key, nonce, ad, ct, 1'b1, et, 1'b0, -1, 0, 1'b0, got);
        for (int i = 0; i < 13; i++) chk($sformatf("rt_pt%0d", i), got[i], i);
`ifdef ASCON_TAG_CHECK_EN
        chk("rt_status", got[13], 8'h01);
        run_txn("badtag", key, nonce, ad, ct, 1'b1, et ^ 128'h1, 1'b0, -1, 0, 1'b0, got);
        chk("badtag_status", got[13], 8'h00);
`endif

        run_txn("bp", key, nonce, ad, data, 1'b0, '0, 1'b0, 7, 5, 1'b0, got);
        chk("bp_size", got.size(), 29);
        run_txn("gap", key, nonce, ad, data, 1'b0, '0, 1'b1, -1, 0, 1'b0, got);
        for (int i = 0; i < 29; i++) chk($sformatf("gap_vs_enc%0d", i), got[i], ref_out[i]);

        build(key, nonce, ad, data, 1'b0, '0, got);
        feed("rstw", got, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_m_valid", m_valid, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_core_start", core_start, 0);
        chk("rstw_s_ready", s_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_ld_key", s_ready, 1);
        run_txn("fresh", key, nonce, ad, data, 1'b0, '0, 1'b0, -1, 0, 1'b0, got);

        for (int t = 0; t < 6; t++) begin
            logic [127:0] rk, rn, re;
            logic [39:0]  ra;
            logic [103:0] rd;
            rk = {$urandom, $urandom, $urandom, $urandom};
            rn = {$urandom, $urandom, $urandom, $urandom};
            re = {$urandom, $urandom, $urandom, $urandom};
            ra = 40'({$urandom, $urandom});
            rd = 104'({$urandom, $urandom, $urandom, $urandom});
            run_txn($sformatf("rnd%0d", t), rk, rn, ra, rd, 1'($urandom), re, 1'($urandom),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 4)), 1'b1, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
